// File: rtl/imem_ctrl_if.sv
// -----------------------------------------------------------------------------
// imem_ctrl_if
// Bundles the two requester ports (core fetch, program loader) and the RAM
// port of the instruction-memory controller.
//   fetch_*  : read-only core fetch port (byte address, error-qualified reply)
//   ldr_*    : loader/debug port (word address, read or write)
//   mem_*    : single-port synchronous RAM, 1-cycle read latency
// Modports:
//   slave  : the controller view (takes requests, drives the RAM)
//   master : the environment view (requesters plus RAM model)
// -----------------------------------------------------------------------------
interface imem_ctrl_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [31:0]       fetch_rdata;
    logic              fetch_err;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [31:0]       ldr_wdata;
    logic              ldr_gnt;
    logic              ldr_rvalid;
    logic [31:0]       ldr_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr,
        output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output fetch_req, fetch_addr,
        input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/imem_ctrl.sv
// -----------------------------------------------------------------------------
// imem_ctrl
// Access controller / arbiter for the single-port instruction RAM behind the
// IFU. Shares the RAM between the core fetch port and the loader port, clears
// the RAM after reset (INIT_CLEAR=1) and answers misaligned or out-of-window
// fetches with an error reply (NOP data) without touching the RAM.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   bus        : imem_ctrl_if.slave (fetch port, loader port, RAM port)
//   init_busy  : high while the post-reset RAM clear runs
// -----------------------------------------------------------------------------
module imem_ctrl #(
    parameter int unsigned ADDR_W        = 10,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int unsigned MAX_LDR_BURST = 4,
    parameter bit          INIT_CLEAR    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    imem_ctrl_if.slave bus,
    output logic       init_busy
);
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [3:0]  BURST_MAX = 4'(MAX_LDR_BURST);

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    localparam state_t RESET_STATE = INIT_CLEAR ? ST_INIT : ST_RUN;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [3:0]        burst_q, burst_d;
    logic              f_rvalid_q, f_rvalid_d;
    logic              f_err_q, f_err_d;
    logic              l_rvalid_q, l_rvalid_d;
    logic [31:0]       f_rdata_q, f_rdata_d;
    logic [31:0]       l_rdata_q, l_rdata_d;

    logic              run;
    logic              addr_err;
    logic              fetch_ok;
    logic              ldr_gnt;
    logic              fetch_gnt;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       f_rdata_now;
    logic [31:0]       l_rdata_now;

    always_comb begin
        run = (state_q == ST_RUN);

        // BASE_ADDR is aligned to the window size, so the window test reduces
        // to comparing the bits above the word index.
        addr_err = (bus.fetch_addr[1:0] != 2'b00) ||
                   (bus.fetch_addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);

        // fetch_ok: a fetch that needs the RAM is pending.
        fetch_ok  = run && bus.fetch_req && !addr_err;
        ldr_gnt   = run && bus.ldr_req && !(fetch_ok && (burst_q == BURST_MAX));
        // Error fetches never compete for the RAM, so they are granted at once.
        fetch_gnt = run && bus.fetch_req && (addr_err || !ldr_gnt);

        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ST_INIT) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = clr_cnt_q;
        end else if (ldr_gnt) begin
            mem_en    = 1'b1;
            mem_we    = bus.ldr_we;
            mem_addr  = bus.ldr_addr;
            mem_wdata = bus.ldr_wdata;
        end else if (fetch_gnt && !addr_err) begin
            mem_en   = 1'b1;
            mem_addr = bus.fetch_addr[ADDR_W+1:2];
        end

        // The registered rvalid/err flags from the grant cycle act as the
        // owner flags that steer mem_rdata; each rdata holds when idle.
        f_rdata_now = f_rvalid_q ? (f_err_q ? NOP : bus.mem_rdata) : f_rdata_q;
        l_rdata_now = l_rvalid_q ? bus.mem_rdata : l_rdata_q;

        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_INIT) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (&clr_cnt_q) begin
                state_d = ST_RUN;
            end
        end

        // Burst count only means something while a RAM fetch is waiting.
        burst_d = burst_q;
        if (!fetch_ok || fetch_gnt) begin
            burst_d = '0;
        end else if (ldr_gnt && (burst_q != BURST_MAX)) begin
            burst_d = burst_q + 4'd1;
        end

        f_rvalid_d = fetch_gnt;
        f_err_d    = fetch_gnt && addr_err;
        l_rvalid_d = ldr_gnt && !bus.ldr_we;
        f_rdata_d  = f_rdata_now;
        l_rdata_d  = l_rdata_now;
    end

    // Every output is forced low while reset is asserted, including any
    // response that was due in the reset cycle.
    always_comb begin
        bus.fetch_gnt    = !reset && fetch_gnt;
        bus.fetch_rvalid = !reset && f_rvalid_q;
        bus.fetch_err    = !reset && f_rvalid_q && f_err_q;
        bus.fetch_rdata  = reset ? '0 : f_rdata_now;
        bus.ldr_gnt      = !reset && ldr_gnt;
        bus.ldr_rvalid   = !reset && l_rvalid_q;
        bus.ldr_rdata    = reset ? '0 : l_rdata_now;
        bus.mem_en       = !reset && mem_en;
        bus.mem_we       = !reset && mem_we;
        bus.mem_addr     = reset ? '0 : mem_addr;
        bus.mem_wdata    = reset ? '0 : mem_wdata;
        init_busy        = !reset && (state_q == ST_INIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            clr_cnt_q  <= '0;
            burst_q    <= '0;
            f_rvalid_q <= 1'b0;
            f_err_q    <= 1'b0;
            l_rvalid_q <= 1'b0;
            f_rdata_q  <= '0;
            l_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            burst_q    <= burst_d;
            f_rvalid_q <= f_rvalid_d;
            f_err_q    <= f_err_d;
            l_rvalid_q <= l_rvalid_d;
            f_rdata_q  <= f_rdata_d;
            l_rdata_q  <= l_rdata_d;
        end
    end
endmodule
